// File: rtl/mem_arbiter.sv
// Single-port arbiter for the slow line memory shared by the I-cache and D-cache.
// D-cache wins ties, but after MAX_D_RUN consecutive D grants over a waiting I-cache, I gets the next grant.
module mem_arbiter #(
   parameter int ADDR_W    = 28,
   parameter int DATA_W    = 128,
   parameter int MAX_D_RUN = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_mem_wdata,
   output logic [DATA_W-1:0] i_mem_rdata,
   output logic              i_mem_ready,
   input  logic              d_mem_read,
   input  logic              d_mem_write,
   input  logic [ADDR_W-1:0] d_mem_addr,
   input  logic [DATA_W-1:0] d_mem_wdata,
   output logic [DATA_W-1:0] d_mem_rdata,
   output logic              d_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              owner_d
);

   // state   | meaning
   // S_IDLE  | no transaction; arbitrate pending requests
   // S_BUSY_I| latched I-cache transaction on the memory port
   // S_BUSY_D| latched D-cache transaction on the memory port
   // S_GAP   | one dead cycle so memory sees a deassert between transactions

   localparam int RUN_W = $clog2(MAX_D_RUN + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_GAP} state_t;

   state_t              state_q, state_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                owner_d_q, owner_d_d;
   logic [RUN_W-1:0]    d_run_q, d_run_d;

   logic i_pend, d_pend, grant_d, grant_i;

   assign i_pend  = i_mem_read | i_mem_write;
   assign d_pend  = d_mem_read | d_mem_write;
   assign grant_d = d_pend & (~i_pend | (d_run_q != RUN_W'(MAX_D_RUN)));
   assign grant_i = i_pend & ~grant_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         owner_d_q <= 1'b0;
         d_run_q   <= '0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         owner_d_q <= owner_d_d;
         d_run_q   <= d_run_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      owner_d_d = owner_d_q;
      d_run_d   = d_run_q;
      case (state_q)
         S_IDLE: begin
            // A requester raising both read and write is treated as a write.
            if (grant_d) begin
               state_d   = S_BUSY_D;
               wr_d      = d_mem_write;
               rd_d      = d_mem_read & ~d_mem_write;
               addr_d    = d_mem_addr;
               wdata_d   = d_mem_wdata;
               owner_d_d = 1'b1;
               if (!i_pend)
                  d_run_d = '0;
               else if (d_run_q != RUN_W'(MAX_D_RUN))
                  d_run_d = d_run_q + RUN_W'(1);
            end else if (grant_i) begin
               state_d   = S_BUSY_I;
               wr_d      = i_mem_write;
               rd_d      = i_mem_read & ~i_mem_write;
               addr_d    = i_mem_addr;
               wdata_d   = i_mem_wdata;
               owner_d_d = 1'b0;
               d_run_d   = '0;
            end
         end
         S_BUSY_I, S_BUSY_D: begin
            if (mem_ready) begin
               state_d = S_GAP;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_read    = rd_q;
   assign mem_write   = wr_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign owner_d     = owner_d_q;
   assign i_mem_rdata = mem_rdata;
   assign d_mem_rdata = mem_rdata;
   assign i_mem_ready = (state_q == S_BUSY_I) & mem_ready;
   assign d_mem_ready = (state_q == S_BUSY_D) & mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven and outputs sampled on the falling edge,
// with a hand-driven slow-memory responder.
module tb_mem_arbiter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write;
   logic [27:0]   i_mem_addr, d_mem_addr, mem_addr;
   logic [127:0]  i_mem_wdata, d_mem_wdata, i_mem_rdata, d_mem_rdata;
   logic          i_mem_ready, d_mem_ready;
   logic          mem_read, mem_write, mem_ready, owner_d;
   logic [127:0]  mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(28), .DATA_W(128), .MAX_D_RUN(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
      .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
      .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .owner_d(owner_d)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits for the next transaction, checks it, completes it after lat cycles, checks the GAP cycle.
   task automatic serve(input string tag, input logic exp_d, input logic exp_wr,
                        input logic [27:0] exp_addr, input logic [127:0] exp_wdata,
                        input int lat, input bit drop);
      int n;
      logic [127:0] rdv;
      n = 0;
      while (!(mem_read || mem_write) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_started"}, 128'(n < 20), 128'd1);
      chk({tag, "_owner"}, 128'(owner_d), 128'(exp_d));
      chk({tag, "_wr"}, 128'(mem_write), 128'(exp_wr));
      chk({tag, "_rd"}, 128'(mem_read), 128'(!exp_wr));
      chk({tag, "_addr"}, 128'(mem_addr), 128'(exp_addr));
      if (exp_wr) chk({tag, "_wdata"}, mem_wdata, exp_wdata);
      if (drop) begin
         i_mem_read = 0; i_mem_write = 0; d_mem_read = 0; d_mem_write = 0;
      end
      repeat (lat - 1) @(negedge clk);
      chk({tag, "_hold_rw"}, 128'({mem_read, mem_write}), 128'({!exp_wr, exp_wr}));
      chk({tag, "_hold_addr"}, 128'(mem_addr), 128'(exp_addr));
      rdv = {32'hCAFE0000, 68'h0, exp_addr};
      mem_rdata = rdv;
      mem_ready = 1;
      #1;
      chk({tag, "_i_ready"}, 128'(i_mem_ready), 128'(!exp_d));
      chk({tag, "_d_ready"}, 128'(d_mem_ready), 128'(exp_d));
      chk({tag, "_rdata"}, exp_d ? d_mem_rdata : i_mem_rdata, rdv);
      @(negedge clk);
      mem_ready = 0;
      mem_rdata = '0;
      chk({tag, "_gap_rw"}, 128'({mem_read, mem_write}), 128'd0);
      chk({tag, "_gap_ready"}, 128'({i_mem_ready, d_mem_ready}), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0;
      i_mem_read = 0; i_mem_write = 0; i_mem_addr = '0; i_mem_wdata = '0;
      d_mem_read = 0; d_mem_write = 0; d_mem_addr = '0; d_mem_wdata = '0;
      mem_rdata = '0; mem_ready = 0;
      #1;
      chk("rst_rw", 128'({mem_read, mem_write}), 128'd0);
      chk("rst_addr", 128'(mem_addr), 128'd0);
      chk("rst_wdata", mem_wdata, 128'd0);
      chk("rst_owner", 128'(owner_d), 128'd0);
      chk("rst_ready", 128'({i_mem_ready, d_mem_ready}), 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1;

      // stray mem_ready while IDLE is ignored
      @(negedge clk);
      mem_ready = 1;
      #1;
      chk("idle_ready_ignored", 128'({i_mem_ready, d_mem_ready}), 128'd0);
      @(negedge clk);
      mem_ready = 0;
      chk("idle_still_idle", 128'({mem_read, mem_write}), 128'd0);

      // 1: I read, one-cycle arbitration latency, memory latency 4
      i_mem_read = 1; i_mem_addr = 28'h0000010;
      @(negedge clk);
      chk("t1_latency", 128'(mem_read), 128'd1);
      serve("t1", 1'b0, 1'b0, 28'h0000010, '0, 4, 0);
      i_mem_read = 0;

      // 2: simultaneous I and D reads: D first, then I
      i_mem_read = 1; i_mem_addr = 28'h0000040;
      d_mem_read = 1; d_mem_addr = 28'h0000050;
      serve("t2_d", 1'b1, 1'b0, 28'h0000050, '0, 2, 0);
      d_mem_read = 0;
      serve("t2_i", 1'b0, 1'b0, 28'h0000040, '0, 3, 0);
      i_mem_read = 0;

      // 3: D writeback (read+write both high -> write wins) then allocate read
      d_mem_write = 1; d_mem_read = 1; d_mem_addr = 28'h0000020;
      d_mem_wdata = 128'h0123456789ABCDEF_FEDCBA9876543210;
      serve("t3_wb", 1'b1, 1'b1, 28'h0000020, 128'h0123456789ABCDEF_FEDCBA9876543210, 2, 0);
      d_mem_write = 0; d_mem_read = 1; d_mem_addr = 28'h0000030;
      @(negedge clk);
      chk("t3_idle_low", 128'({mem_read, mem_write}), 128'd0);
      @(negedge clk);
      chk("t3_alloc_start", 128'(mem_read), 128'd1);
      serve("t3_alloc", 1'b1, 1'b0, 28'h0000030, '0, 1, 0);

      // 4: starvation bound: D,D,D,D,I then D wins again with d_run cleared
      i_mem_read = 1; i_mem_addr = 28'h0000060;
      d_mem_addr = 28'h0000070;
      for (int k = 0; k < 4; k++) begin
         serve($sformatf("t4_d%0d", k), 1'b1, 1'b0, 28'h0000070 + 28'(k), '0, 1, 0);
         d_mem_addr = 28'h0000071 + 28'(k);
      end
      serve("t4_i", 1'b0, 1'b0, 28'h0000060, '0, 1, 0);
      i_mem_addr = 28'h0000068;
      serve("t4_d_after", 1'b1, 1'b0, 28'h0000074, '0, 1, 0);
      d_mem_read = 0;
      serve("t4_i2", 1'b0, 1'b0, 28'h0000068, '0, 1, 0);
      i_mem_read = 0;

      // 5: D drops its request mid-transaction; transaction still completes
      d_mem_read = 1; d_mem_addr = 28'h0000090;
      serve("t5", 1'b1, 1'b0, 28'h0000090, '0, 4, 1);

      // 6: async reset mid BUSY_I, then normal operation
      i_mem_read = 1; i_mem_addr = 28'h00000A0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_busy", 128'(mem_read), 128'd1);
      #2 rst_n = 0;
      #1;
      chk("t6_rst_rd", 128'(mem_read), 128'd0);
      chk("t6_rst_owner_addr", 128'({owner_d, mem_addr}), 128'd0);
      mem_ready = 1;
      #1;
      chk("t6_rst_ready", 128'({i_mem_ready, d_mem_ready}), 128'd0);
      mem_ready = 0;
      i_mem_read = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      i_mem_read = 1; i_mem_addr = 28'h00000B0;
      serve("t6_after", 1'b0, 1'b0, 28'h00000B0, '0, 2, 0);
      i_mem_read = 0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
